axis_pkt_wrr_arb: RTL and testbench

Packet-aware weighted round-robin arbiter that joins MASTER_NUM AXI-Stream sources onto one AXI-Stream sink. A grant is locked for a whole packet, through the beat carrying tlast, so packets never interleave. Each source may send up to its programmed weight of consecutive packets per turn. It sits in front of a shared stream consumer (DMA write channel, shared FIFO, UART TX) and tags each beat with the source index on m_tuser.

---
 rtl/axis_pkt_wrr_arb.sv | 126 ++++++++++++
 tb/tb_axis_pkt_wrr_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_wrr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_pkt_wrr_arb: packet-locked weighted round-robin AXI-Stream merger.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_pkt_wrr_arb #(
    parameter int MASTER_NUM   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 4,
    parameter int PTR_WIDTH    = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weight_i,
    input  logic [MASTER_NUM-1:0]              s_tvalid_i,
    output logic [MASTER_NUM-1:0]              s_tready_o,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0]   s_tdata_i,
    input  logic [MASTER_NUM-1:0]              s_tlast_i,
    output logic                               m_tvalid_o,
    input  logic                               m_tready_i,
    output logic [DATA_WIDTH-1:0]              m_tdata_o,
    output logic                               m_tlast_o,
    output logic [PTR_WIDTH-1:0]               m_tuser_o,
    output logic                               busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [PTR_WIDTH-1:0] C_LAST_IDX = PTR_WIDTH'(MASTER_NUM - 1);

    state_t                  r_state, w_state_nxt;
    logic [PTR_WIDTH-1:0]    r_gnt, w_gnt_nxt;
    logic [PTR_WIDTH-1:0]    r_ptr, w_ptr_nxt;
    logic [WEIGHT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                    r_hold, w_hold_nxt;

    logic                    w_any;
    logic [PTR_WIDTH-1:0]    w_win;
    logic [PTR_WIDTH-1:0]    w_gnt_inc;
    logic [WEIGHT_WIDTH-1:0] w_weight;
    logic                    w_sel_valid;
    logic                    w_sel_last;

    // First valid requester scanning upward from r_ptr, wrapping at MASTER_NUM.
    always_comb begin : p_scan
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= MASTER_NUM) begin
                idx = idx - MASTER_NUM;
            end
            if (!w_any && s_tvalid_i[PTR_WIDTH'(idx)]) begin
                w_any = 1'b1;
                w_win = PTR_WIDTH'(idx);
            end
        end
    end

    assign w_weight    = weight_i[int'(w_win)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_gnt_inc   = (r_gnt == C_LAST_IDX) ? '0 : r_gnt + PTR_WIDTH'(1);
    assign w_sel_valid = s_tvalid_i[r_gnt];
    assign w_sel_last  = s_tlast_i[r_gnt];

    assign m_tdata_o   = s_tdata_i[int'(r_gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign m_tlast_o   = w_sel_last;
    assign m_tuser_o   = r_gnt;
    assign busy_o      = (r_state == ST_LOCK);

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        m_tvalid_o  = 1'b0;
        s_tready_o  = '0;
        if (r_state == ST_IDLE) begin
            if (w_any) begin
                w_gnt_nxt   = w_win;
                w_state_nxt = ST_LOCK;
                // A held turn keeps its remaining credit only if that same source wins again.
                if (!(r_hold && (w_win == r_ptr))) begin
                    w_cnt_nxt = (w_weight == '0) ? WEIGHT_WIDTH'(1) : w_weight;
                end
            end
        end else begin
            m_tvalid_o        = w_sel_valid;
            s_tready_o[r_gnt] = m_tready_i;
            if (w_sel_valid && m_tready_i && w_sel_last) begin
                w_state_nxt = ST_IDLE;
                if (r_cnt == WEIGHT_WIDTH'(1)) begin
                    w_ptr_nxt  = w_gnt_inc;
                    w_hold_nxt = 1'b0;
                end else begin
                    w_cnt_nxt  = r_cnt - WEIGHT_WIDTH'(1);
                    w_ptr_nxt  = r_gnt;
                    w_hold_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_wrr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_pkt_wrr_arb: directed vectors for axis_pkt_wrr_arb (4 and 3 src).|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axis_pkt_wrr_arb;

    logic         clk = 1'b0;
    logic         rstn;
    logic [15:0]  weight;
    logic [3:0]   s_tvalid, s_tready, s_tlast;
    logic [127:0] s_tdata;
    logic         m_tvalid, m_tready, m_tlast, busy;
    logic [31:0]  m_tdata;
    logic [1:0]   m_tuser;

    logic [11:0]  weight3 = 12'h000;
    logic [2:0]   v3, s3_tready;
    logic [2:0]   tlast3 = 3'b111;
    logic [95:0]  tdata3 = {32'hC2, 32'hC1, 32'hC0};
    logic         m3_tvalid, m3_tlast, busy3;
    logic [31:0]  m3_tdata;
    logic [1:0]   m3_tuser;

    int errors = 0;
    int checks = 0;

    logic [3:0] vmask;
    logic       rdy;
    int len[4];
    int beat[4];
    int pkt[4];

    always #5 clk = ~clk;

    axis_pkt_wrr_arb #(.MASTER_NUM(4), .DATA_WIDTH(32), .WEIGHT_WIDTH(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .weight_i(weight),
        .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast),
        .m_tuser_o(m_tuser), .busy_o(busy)
    );

    axis_pkt_wrr_arb #(.MASTER_NUM(3), .DATA_WIDTH(32), .WEIGHT_WIDTH(4)) dut3 (
        .clk_i(clk), .rstn_i(rstn), .weight_i(weight3),
        .s_tvalid_i(v3), .s_tready_o(s3_tready), .s_tdata_i(tdata3), .s_tlast_i(tlast3),
        .m_tvalid_o(m3_tvalid), .m_tready_i(1'b1), .m_tdata_o(m3_tdata), .m_tlast_o(m3_tlast),
        .m_tuser_o(m3_tuser), .busy_o(busy3)
    );

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_user;
        logic [3:0] exp_sready;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic [3:0] v, logic r, logic ev, logic [1:0] eu, logic [3:0] es);
        vec_t t;
        t.valid = v; t.ready = r; t.exp_valid = ev; t.exp_user = eu; t.exp_sready = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        s_tvalid = vmask;
        m_tready = rdy;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i*32 +: 32] = {8'(i), 8'(pkt[i]), 16'(beat[i])};
            s_tlast[i]          = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic src_reset(input int l);
        for (int i = 0; i < 4; i++) begin
            len[i] = l; beat[i] = 0; pkt[i] = 0;
        end
        vmask = 4'h0;
        rdy   = 1'b1;
        apply();
    endtask

    // Sources advance on the handshake seen just before the edge, then outputs settle.
    task automatic tick(input logic [3:0] nv, input logic nr);
        logic [3:0] hs;
        hs = s_tvalid & s_tready;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        vmask = nv;
        rdy   = nr;
        apply();
        #1;
    endtask

    task automatic tick3(input logic [2:0] nv);
        @(posedge clk); #1;
        v3 = nv;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        v3   = 3'b000;
        src_reset(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin : main
        int exp_beat[10]     = '{-1, 0, 1, 1, 1, 2, 3, 4, -1, 0};
        logic rdy_pat[10]    = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int exp_u3[12]       = '{-1, 2, -1, 2, -1, 2, -1, 0, -1, 2, -1, 0};

        weight = 16'h1111;
        do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd0);
        chk("rst_tuser",  64'(m_tuser),  64'd0);
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst3_tvalid", 64'(m3_tvalid), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Equal weights, 3-beat packets, every source always valid.
        src_reset(3);
        for (int c = 0; c < 32; c++) begin
            int ph, pk;
            tick(4'hF, 1'b1);
            ph = c % 4;
            pk = c / 4;
            chk("rr_tvalid", 64'(m_tvalid), 64'(ph != 0));
            if (ph != 0) begin
                chk("rr_tuser", 64'(m_tuser), 64'(pk % 4));
                chk("rr_tdata", 64'(m_tdata), 64'({8'(pk % 4), 8'(pk / 4), 16'(ph - 1)}));
                chk("rr_tlast", 64'(m_tlast), 64'(ph == 3));
            end
        end

        // Weighted turns {2,1,3,1} with 1-beat packets, credit forfeit and stalls.
        weight = {4'd1, 4'd3, 4'd1, 4'd2};
        do_reset();
        tbl[0]  = mk(4'hF, 1, 0, 0, 4'h0);
        tbl[1]  = mk(4'hF, 1, 1, 0, 4'h1);
        tbl[2]  = mk(4'hF, 1, 0, 0, 4'h0);
        tbl[3]  = mk(4'hF, 1, 1, 0, 4'h1);
        tbl[4]  = mk(4'hF, 1, 0, 0, 4'h0);
        tbl[5]  = mk(4'hF, 1, 1, 1, 4'h2);
        tbl[6]  = mk(4'hF, 1, 0, 1, 4'h0);
        tbl[7]  = mk(4'hF, 1, 1, 2, 4'h4);
        tbl[8]  = mk(4'hF, 1, 0, 2, 4'h0);
        tbl[9]  = mk(4'hF, 1, 1, 2, 4'h4);
        tbl[10] = mk(4'hF, 1, 0, 2, 4'h0);
        tbl[11] = mk(4'hF, 1, 1, 2, 4'h4);
        tbl[12] = mk(4'hF, 1, 0, 2, 4'h0);
        tbl[13] = mk(4'hF, 1, 1, 3, 4'h8);
        tbl[14] = mk(4'hF, 1, 0, 3, 4'h0);
        tbl[15] = mk(4'hF, 1, 1, 0, 4'h1);
        tbl[16] = mk(4'h8, 1, 0, 0, 4'h0);
        tbl[17] = mk(4'h8, 1, 1, 3, 4'h8);
        tbl[18] = mk(4'hF, 1, 0, 3, 4'h0);
        tbl[19] = mk(4'hF, 1, 1, 0, 4'h1);
        tbl[20] = mk(4'hF, 1, 0, 0, 4'h0);
        tbl[21] = mk(4'hF, 1, 1, 0, 4'h1);
        tbl[22] = mk(4'hF, 1, 0, 0, 4'h0);
        tbl[23] = mk(4'hF, 0, 1, 1, 4'h0);
        tbl[24] = mk(4'hF, 0, 1, 1, 4'h0);
        tbl[25] = mk(4'hF, 1, 1, 1, 4'h2);
        tbl[26] = mk(4'hF, 1, 0, 1, 4'h0);
        for (int r = 0; r < 27; r++) begin
            tick(tbl[r].valid, tbl[r].ready);
            chk($sformatf("wrr%0d_tvalid", r), 64'(m_tvalid), 64'(tbl[r].exp_valid));
            chk($sformatf("wrr%0d_tuser", r),  64'(m_tuser),  64'(tbl[r].exp_user));
            chk($sformatf("wrr%0d_sready", r), 64'(s_tready), 64'(tbl[r].exp_sready));
            chk($sformatf("wrr%0d_busy", r),   64'(busy),     64'(tbl[r].exp_valid));
            if (tbl[r].exp_valid) begin
                chk($sformatf("wrr%0d_src", r), 64'(m_tdata[31:24]), 64'(tbl[r].exp_user));
            end
        end

        // Source 1 holds a 5-beat packet under backpressure while source 2 requests.
        weight = 16'h1111;
        do_reset();
        src_reset(1);
        len[1] = 5;
        for (int c = 0; c < 10; c++) begin
            tick((c < 2) ? 4'b0010 : 4'b0110, rdy_pat[c]);
            chk("lock_tvalid", 64'(m_tvalid), 64'(exp_beat[c] >= 0));
            if (c < 9) begin
                chk("lock_sready2", 64'(s_tready[2]), 64'd0);
            end
            if (exp_beat[c] >= 0) begin
                logic [1:0] u;
                u = (c == 9) ? 2'd2 : 2'd1;
                chk("lock_tuser", 64'(m_tuser), 64'(u));
                chk("lock_tdata", 64'(m_tdata), 64'({8'(u), 8'd0, 16'(exp_beat[c])}));
                chk("lock_sready", 64'(s_tready), 64'(rdy_pat[c] ? (4'b0001 << u) : 4'b0000));
                if (c < 9) begin
                    chk("lock_tlast", 64'(m_tlast), 64'(exp_beat[c] == 4));
                end
            end
        end

        // Three sources, zero weights: wrap from 2 back to 0, weight 0 acts as 1.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick3((c < 6) ? 3'b100 : 3'b101);
            chk("m3_tvalid", 64'(m3_tvalid), 64'(exp_u3[c] >= 0));
            chk("m3_busy", 64'(busy3), 64'(exp_u3[c] >= 0));
            if (exp_u3[c] >= 0) begin
                chk("m3_tuser", 64'(m3_tuser), 64'(exp_u3[c]));
                chk("m3_tdata", 64'(m3_tdata), 64'(32'hC0 + 32'(exp_u3[c])));
                chk("m3_sready", 64'(s3_tready), 64'(3'b001 << exp_u3[c]));
            end
        end

        // Asynchronous reset during beat 2 of a 4-beat packet from source 1.
        do_reset();
        src_reset(4);
        tick(4'b0010, 1'b1);
        chk("ar_idle", 64'(m_tvalid), 64'd0);
        tick(4'b0010, 1'b1);
        chk("ar_b0", 64'(m_tdata), 64'({8'd1, 8'd0, 16'd0}));
        tick(4'b0010, 1'b1);
        chk("ar_b1", 64'(m_tdata), 64'({8'd1, 8'd0, 16'd1}));
        tick(4'b0010, 1'b1);
        chk("ar_b2", 64'(m_tdata), 64'({8'd1, 8'd0, 16'd2}));
        chk("ar_b2_tuser", 64'(m_tuser), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("ar_tvalid", 64'(m_tvalid), 64'd0);
        chk("ar_sready", 64'(s_tready), 64'd0);
        chk("ar_tuser",  64'(m_tuser),  64'd0);
        chk("ar_busy",   64'(busy),     64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        src_reset(4);
        vmask = 4'hF;
        apply();
        #1;
        chk("ar_rel_idle", 64'(m_tvalid), 64'd0);
        tick(4'hF, 1'b1);
        chk("ar_rel_tvalid", 64'(m_tvalid), 64'd1);
        chk("ar_rel_tuser",  64'(m_tuser),  64'd0);
        chk("ar_rel_tdata",  64'(m_tdata),  64'({8'd0, 8'd0, 16'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
